// File: rtl/poly_spi_pkg.sv
// Shared constants, opcodes, frame-length helper and FSM state type for the polygon SPI register file.
// Optional readback is enabled with the POLY_SPI_READBACK_EN macro (see poly_spi_regfile).
package poly_spi_pkg;

  localparam int unsigned NUM_POLY_DEF = 4;
  localparam int unsigned X_W_DEF      = 7;
  localparam int unsigned Y_W_DEF      = 6;
  localparam int unsigned COLOR_W_DEF  = 6;
  localparam int unsigned CMD_W        = 8;

  localparam logic [7:0] OP_LOAD      = 8'h80;
  localparam logic [7:0] OP_CLEAR     = 8'h40;
  localparam logic [7:0] OP_READ      = 8'hC0;
  localparam logic [7:0] OP_BG        = 8'h01;
  localparam logic [7:0] OP_SLOT_MASK = 8'hF8;

  // Total frame length: command byte plus color and three (x,y) vertices.
  function automatic int unsigned frame_w(input int unsigned x_w, input int unsigned y_w,
                                          input int unsigned color_w);
    return CMD_W + color_w + 3 * x_w + 3 * y_w;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_PAYLOAD,
    ST_DONE
  } spi_state_e;

endpackage

// File: rtl/poly_spi_sampler.sv
// Brings the asynchronous SPI pins into the clk domain and detects sck edges.
module poly_spi_sampler (
  input  logic clk,
  input  logic rst_n,
  input  logic cs_in,
  input  logic sck_in,
  input  logic mosi_in,
  output logic cs_sync,
  output logic mosi_sync,
  output logic sck_rise_c,
  output logic sck_fall_c
);

  logic [2:0] sck_q;
  logic       cs_meta;
  logic       mosi_meta;

  // Chip select resets to its inactive (high) level so no frame starts spuriously.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_q     <= '0;
      cs_meta   <= 1'b1;
      cs_sync   <= 1'b1;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      sck_q     <= {sck_q[1:0], sck_in};
      cs_meta   <= cs_in;
      cs_sync   <= cs_meta;
      mosi_meta <= mosi_in;
      mosi_sync <= mosi_meta;
    end
  end

  assign sck_rise_c = sck_q[1] & ~sck_q[2];
  assign sck_fall_c = ~sck_q[1] & sck_q[2];

endmodule

// File: rtl/poly_spi_regfile.sv
// SPI-loaded polygon register file: one LSB-first frame per command, committed once on completion.
// Define POLY_SPI_READBACK_EN to build the 0xC0|k slot readback path on miso_out.
module poly_spi_regfile
  import poly_spi_pkg::*;
#(
  parameter int unsigned NUM_POLY = NUM_POLY_DEF,
  parameter int unsigned X_W      = X_W_DEF,
  parameter int unsigned Y_W      = Y_W_DEF,
  parameter int unsigned COLOR_W  = COLOR_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cs_in,
  input  logic                        sck_in,
  input  logic                        mosi_in,
  output logic                        miso_out,
  input  logic                        en_load,
  output logic [COLOR_W-1:0]          bg_color_out,
  output logic [NUM_POLY*COLOR_W-1:0] poly_color_out,
  output logic [NUM_POLY*X_W-1:0]     v0_x_out,
  output logic [NUM_POLY*X_W-1:0]     v1_x_out,
  output logic [NUM_POLY*X_W-1:0]     v2_x_out,
  output logic [NUM_POLY*Y_W-1:0]     v0_y_out,
  output logic [NUM_POLY*Y_W-1:0]     v1_y_out,
  output logic [NUM_POLY*Y_W-1:0]     v2_y_out,
  output logic [NUM_POLY-1:0]         poly_enable_out,
  output logic                        frame_done,
  output logic                        cmd_err
);

  localparam int unsigned FRAME_W = frame_w(X_W, Y_W, COLOR_W);
  localparam int unsigned PAY_W   = FRAME_W - CMD_W;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
  localparam int unsigned OFF_COL = CMD_W;
  localparam int unsigned OFF_V0X = OFF_COL + COLOR_W;
  localparam int unsigned OFF_V1X = OFF_V0X + X_W;
  localparam int unsigned OFF_V2X = OFF_V1X + X_W;
  localparam int unsigned OFF_V0Y = OFF_V2X + X_W;
  localparam int unsigned OFF_V1Y = OFF_V0Y + Y_W;
  localparam int unsigned OFF_V2Y = OFF_V1Y + Y_W;

  logic cs_sync, mosi_sync, sck_rise_c, sck_fall_c;

  poly_spi_sampler u_sampler (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs_in      (cs_in),
    .sck_in     (sck_in),
    .mosi_in    (mosi_in),
    .cs_sync    (cs_sync),
    .mosi_sync  (mosi_sync),
    .sck_rise_c (sck_rise_c),
    .sck_fall_c (sck_fall_c)
  );

  spi_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [FRAME_W-1:0] frame_q;
  logic               commit_q;
  logic               sample_c, last_bit_c, cmd_bit_c;

  assign sample_c   = sck_rise_c & en_load & ~cs_sync & (state_q != ST_DONE);
  assign cmd_bit_c  = sample_c & (cnt_q == CNT_W'(CMD_W - 1));
  assign last_bit_c = sample_c & (cnt_q == CNT_W'(FRAME_W - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Phase follows the received bit count; cs high aborts from anywhere.
  always_comb begin
    state_d = state_q;
    if (cs_sync) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    state_d = ST_CMD;
        ST_CMD:     if (cmd_bit_c) state_d = ST_PAYLOAD;
        ST_PAYLOAD: if (last_bit_c) state_d = ST_DONE;
        ST_DONE:    state_d = ST_DONE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      frame_q  <= '0;
      commit_q <= 1'b0;
    end else begin
      commit_q <= last_bit_c;
      if (cs_sync) begin
        cnt_q   <= '0;
        frame_q <= '0;
      end else if (sample_c) begin
        frame_q[cnt_q] <= mosi_sync;
        cnt_q          <= cnt_q + CNT_W'(1);
      end
    end
  end

  logic [7:0] cmd_c;
  logic [2:0] slot_c;
  logic       slot_ok_c, is_load_c, is_clear_c, is_bg_c, is_read_c, cmd_ok_c;

  assign cmd_c      = frame_q[CMD_W-1:0];
  assign slot_c     = cmd_c[2:0];
  assign slot_ok_c  = 32'(slot_c) < NUM_POLY;
  assign is_load_c  = ((cmd_c & OP_SLOT_MASK) == OP_LOAD) & slot_ok_c;
  assign is_clear_c = ((cmd_c & OP_SLOT_MASK) == OP_CLEAR) & slot_ok_c;
  assign is_bg_c    = (cmd_c == OP_BG);
`ifdef POLY_SPI_READBACK_EN
  assign is_read_c  = ((cmd_c & OP_SLOT_MASK) == OP_READ) & slot_ok_c;
`else
  assign is_read_c  = 1'b0;
`endif
  assign cmd_ok_c   = is_load_c | is_clear_c | is_bg_c | is_read_c;

  // Single commit per frame; a read command only acknowledges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bg_color_out    <= '0;
      poly_color_out  <= '0;
      v0_x_out        <= '0;
      v1_x_out        <= '0;
      v2_x_out        <= '0;
      v0_y_out        <= '0;
      v1_y_out        <= '0;
      v2_y_out        <= '0;
      poly_enable_out <= '0;
      frame_done      <= 1'b0;
      cmd_err         <= 1'b0;
    end else begin
      frame_done <= commit_q & cmd_ok_c;
      cmd_err    <= commit_q & ~cmd_ok_c;
      if (commit_q && is_bg_c) bg_color_out <= frame_q[OFF_COL +: COLOR_W];
      for (int k = 0; k < int'(NUM_POLY); k++) begin
        if (commit_q && slot_c == 3'(k)) begin
          if (is_load_c) begin
            poly_color_out[k*COLOR_W +: COLOR_W] <= frame_q[OFF_COL +: COLOR_W];
            v0_x_out[k*X_W +: X_W]               <= frame_q[OFF_V0X +: X_W];
            v1_x_out[k*X_W +: X_W]               <= frame_q[OFF_V1X +: X_W];
            v2_x_out[k*X_W +: X_W]               <= frame_q[OFF_V2X +: X_W];
            v0_y_out[k*Y_W +: Y_W]               <= frame_q[OFF_V0Y +: Y_W];
            v1_y_out[k*Y_W +: Y_W]               <= frame_q[OFF_V1Y +: Y_W];
            v2_y_out[k*Y_W +: Y_W]               <= frame_q[OFF_V2Y +: Y_W];
            poly_enable_out[k]                   <= 1'b1;
          end else if (is_clear_c) begin
            poly_color_out[k*COLOR_W +: COLOR_W] <= '0;
            v0_x_out[k*X_W +: X_W]               <= '0;
            v1_x_out[k*X_W +: X_W]               <= '0;
            v2_x_out[k*X_W +: X_W]               <= '0;
            v0_y_out[k*Y_W +: Y_W]               <= '0;
            v1_y_out[k*Y_W +: Y_W]               <= '0;
            v2_y_out[k*Y_W +: Y_W]               <= '0;
            poly_enable_out[k]                   <= 1'b0;
          end
        end
      end
    end
  end

`ifdef POLY_SPI_READBACK_EN
  logic [PAY_W-1:0] tx_q, rd_pay_c;
  logic [7:0]       cmd_live_c;
  logic             rd_active_q, load_rd_c;

  // The command byte is complete including the bit being sampled right now.
  assign cmd_live_c = {mosi_sync, frame_q[CMD_W-2:0]};
  assign load_rd_c  = cmd_bit_c & ((cmd_live_c & OP_SLOT_MASK) == OP_READ)
                    & (32'(cmd_live_c[2:0]) < NUM_POLY);

  always_comb begin
    rd_pay_c = '0;
    for (int k = 0; k < int'(NUM_POLY); k++) begin
      if (cmd_live_c[2:0] == 3'(k)) begin
        rd_pay_c = {v2_y_out[k*Y_W +: Y_W], v1_y_out[k*Y_W +: Y_W], v0_y_out[k*Y_W +: Y_W],
                    v2_x_out[k*X_W +: X_W], v1_x_out[k*X_W +: X_W], v0_x_out[k*X_W +: X_W],
                    poly_color_out[k*COLOR_W +: COLOR_W]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || cs_sync) begin
      tx_q        <= '0;
      rd_active_q <= 1'b0;
      miso_out    <= 1'b0;
    end else if (load_rd_c) begin
      tx_q        <= rd_pay_c;
      rd_active_q <= 1'b1;
    end else if (sck_fall_c && rd_active_q) begin
      miso_out <= tx_q[0];
      tx_q     <= tx_q >> 1;
    end
  end
`else
  logic unused_c;
  assign unused_c = sck_fall_c;
  assign miso_out = 1'b0;
`endif

endmodule

// File: tb/tb_poly_spi_regfile.sv
// Directed bench for poly_spi_regfile: bit-banged SPI frames with hand-computed register expectations.
`timescale 1ns/1ps
module tb_poly_spi_regfile;
  import poly_spi_pkg::*;

  localparam int unsigned FW   = 53;
  localparam int          HALF = 8;

  logic        clk = 1'b0;
  logic        rst_n, cs_in, sck_in, mosi_in, en_load, miso_out;
  logic [5:0]  bg_color_out;
  logic [23:0] poly_color_out, v0_y_out, v1_y_out, v2_y_out;
  logic [27:0] v0_x_out, v1_x_out, v2_x_out;
  logic [3:0]  poly_enable_out;
  logic        frame_done, cmd_err;

  int          checks = 0;
  int          failures = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          d0, e0;
  logic [3:0]  en_at_done = '0;
  logic [5:0]  bg_at_done = '0;
  logic [44:0] rx;
  logic [63:0] f_slot2;

  poly_spi_regfile dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cs_in           (cs_in),
    .sck_in          (sck_in),
    .mosi_in         (mosi_in),
    .miso_out        (miso_out),
    .en_load         (en_load),
    .bg_color_out    (bg_color_out),
    .poly_color_out  (poly_color_out),
    .v0_x_out        (v0_x_out),
    .v1_x_out        (v1_x_out),
    .v2_x_out        (v2_x_out),
    .v0_y_out        (v0_y_out),
    .v1_y_out        (v1_y_out),
    .v2_y_out        (v2_y_out),
    .poly_enable_out (poly_enable_out),
    .frame_done      (frame_done),
    .cmd_err         (cmd_err)
  );

  always #5 clk = ~clk;

  // Pulse counters; also capture what the outputs show in the frame_done cycle.
  always @(negedge clk) begin
    if (frame_done) begin
      done_cnt++;
      en_at_done = poly_enable_out;
      bg_at_done = bg_color_out;
    end
    if (cmd_err) err_cnt++;
  end

  function automatic logic [63:0] mk(input logic [7:0] cmd, input logic [5:0] col,
                                     input logic [6:0] v0x, input logic [6:0] v1x,
                                     input logic [6:0] v2x, input logic [5:0] v0y,
                                     input logic [5:0] v1y, input logic [5:0] v2y);
    return 64'({v2y, v1y, v0y, v2x, v1x, v0x, col, cmd});
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Master drives mosi while sck is low and samples miso just before each rise.
  task automatic send(input logic [63:0] data, input int nbits, input logic en);
    rx      = '0;
    en_load = en;
    cs_in   = 1'b0;
    sck_in  = 1'b0;
    tick(HALF);
    for (int i = 0; i < nbits; i++) begin
      sck_in  = 1'b0;
      mosi_in = data[i];
      tick(HALF);
      #1;
      if (i >= 8 && i < int'(FW)) rx[i-8] = miso_out;
      sck_in = 1'b1;
      tick(HALF);
    end
    sck_in = 1'b0;
    tick(HALF);
  endtask

  task automatic end_frame();
    cs_in   = 1'b1;
    en_load = 1'b1;
    tick(HALF);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; cs_in = 1'b1; sck_in = 1'b0; mosi_in = 1'b0; en_load = 1'b1;
    tick(4); #1;
    check("rst_bg", 64'(bg_color_out), 64'h0);
    check("rst_color", 64'(poly_color_out), 64'h0);
    check("rst_v1x", 64'(v1_x_out), 64'h0);
    check("rst_enable", 64'(poly_enable_out), 64'h0);
    check("rst_miso", 64'(miso_out), 64'h0);
    check("rst_pulses", 64'({frame_done, cmd_err}), 64'h0);
    rst_n = 1'b1;
    tick(4);

    // Load slot 2.
    f_slot2 = mk(8'h82, 6'h2A, 7'h10, 7'h7F, 7'h00, 6'h05, 6'h3F, 6'h01);
    d0 = done_cnt; e0 = err_cnt;
    send(f_slot2, FW, 1'b1); end_frame();
    check("w2_color", 64'(poly_color_out[17:12]), 64'h2A);
    check("w2_v1x", 64'(v1_x_out[20:14]), 64'h7F);
    check("w2_v0x", 64'(v0_x_out[20:14]), 64'h10);
    check("w2_v0y", 64'(v0_y_out[17:12]), 64'h05);
    check("w2_v1y", 64'(v1_y_out[17:12]), 64'h3F);
    check("w2_v2y", 64'(v2_y_out[17:12]), 64'h01);
    check("w2_color_all", 64'(poly_color_out), 64'h02A000);
    check("w2_enable", 64'(poly_enable_out), 64'h4);
    check("w2_done", 64'(done_cnt - d0), 64'd1);
    check("w2_err", 64'(err_cnt - e0), 64'd0);
    check("w2_en_at_done", 64'(en_at_done), 64'h4);

    // Load slot 0, then clear slot 2 with a nonzero (ignored) payload.
    send(mk(8'h80, 6'h11, 7'h22, 7'h33, 7'h44, 6'h05, 6'h06, 6'h07), FW, 1'b1); end_frame();
    check("w0_enable", 64'(poly_enable_out), 64'h5);
    d0 = done_cnt;
    send(mk(8'h42, 6'h3F, 7'h7F, 7'h7F, 7'h7F, 6'h3F, 6'h3F, 6'h3F), FW, 1'b1); end_frame();
    check("clr_color", 64'(poly_color_out), 64'h000011);
    check("clr_v0x", 64'(v0_x_out), 64'h0000022);
    check("clr_v1x", 64'(v1_x_out), 64'h0000033);
    check("clr_v2y", 64'(v2_y_out), 64'h000007);
    check("clr_enable", 64'(poly_enable_out), 64'h1);
    check("clr_done", 64'(done_cnt - d0), 64'd1);

    // Truncated frame is discarded.
    d0 = done_cnt; e0 = err_cnt;
    send(mk(8'h81, 6'h3C, 7'h11, 7'h11, 7'h11, 6'h11, 6'h11, 6'h11), 30, 1'b1); end_frame();
    check("abort_enable", 64'(poly_enable_out), 64'h1);
    check("abort_color", 64'(poly_color_out), 64'h000011);
    check("abort_pulses", 64'((done_cnt - d0) + (err_cnt - e0)), 64'd0);

    // Background frame with extra trailing bits, which are ignored in DONE.
    d0 = done_cnt;
    send(mk(8'h01, 6'h15, 7'h00, 7'h00, 7'h00, 6'h00, 6'h00, 6'h00), 60, 1'b1); end_frame();
    check("bg_color", 64'(bg_color_out), 64'h15);
    check("bg_done", 64'(done_cnt - d0), 64'd1);
    check("bg_at_done", 64'(bg_at_done), 64'h15);

    // Slot index out of range.
    d0 = done_cnt; e0 = err_cnt;
    send(mk(8'h85, 6'h0A, 7'h01, 7'h02, 7'h03, 6'h04, 6'h05, 6'h06), FW, 1'b1); end_frame();
    check("bad_err", 64'(err_cnt - e0), 64'd1);
    check("bad_done", 64'(done_cnt - d0), 64'd0);
    check("bad_color", 64'(poly_color_out), 64'h000011);
    check("bad_enable", 64'(poly_enable_out), 64'h1);
    check("bad_bg", 64'(bg_color_out), 64'h15);

    // Sampling not permitted: nothing is counted.
    d0 = done_cnt; e0 = err_cnt;
    send(mk(8'h83, 6'h2B, 7'h01, 7'h02, 7'h03, 6'h04, 6'h05, 6'h06), FW, 1'b0); end_frame();
    check("noload_pulses", 64'((done_cnt - d0) + (err_cnt - e0)), 64'd0);
    check("noload_enable", 64'(poly_enable_out), 64'h1);

    // Reload slot 2, then the read command.
    send(f_slot2, FW, 1'b1); end_frame();
    d0 = done_cnt; e0 = err_cnt;
    send(mk(8'hC2, 6'h00, 7'h00, 7'h00, 7'h00, 6'h00, 6'h00, 6'h00), FW, 1'b1); end_frame();
`ifdef POLY_SPI_READBACK_EN
    check("rd_stream", 64'(rx), f_slot2 >> 8);
    check("rd_done", 64'(done_cnt - d0), 64'd1);
    check("rd_err", 64'(err_cnt - e0), 64'd0);
`else
    check("rd_stream", 64'(rx), 64'h0);
    check("rd_done", 64'(done_cnt - d0), 64'd0);
    check("rd_err", 64'(err_cnt - e0), 64'd1);
`endif
    check("rd_enable", 64'(poly_enable_out), 64'h5);
    check("rd_color", 64'(poly_color_out), 64'h02A011);
    check("rd_miso_idle", 64'(miso_out), 64'h0);

    // Reset in the middle of a frame.
    send(mk(8'h83, 6'h2B, 7'h01, 7'h02, 7'h03, 6'h04, 6'h05, 6'h06), 20, 1'b1);
    rst_n = 1'b0;
    tick(3); #1;
    check("mrst_enable", 64'(poly_enable_out), 64'h0);
    check("mrst_bg", 64'(bg_color_out), 64'h0);
    check("mrst_color", 64'(poly_color_out), 64'h0);
    cs_in = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(4);
    d0 = done_cnt;
    send(mk(8'h83, 6'h2B, 7'h01, 7'h02, 7'h03, 6'h04, 6'h05, 6'h06), FW, 1'b1); end_frame();
    check("post_enable", 64'(poly_enable_out), 64'h8);
    check("post_color", 64'(poly_color_out), 64'hAC0000);
    check("post_done", 64'(done_cnt - d0), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/poly_spi_regfile.md
POLY_SPI_REGFILE -- requirements
Module: poly_spi_regfile

Interface
REQ-001 Parameter NUM_POLY, default 4, number of polygon slots (1..8).
REQ-002 Parameter X_W, default 7, vertex x width; Y_W, default 6, vertex y width; COLOR_W, default 6, color width.
REQ-003 Derived constant FRAME_W = 8 + COLOR_W + 3*X_W + 3*Y_W (default 53), the total SPI frame length in bits.
REQ-004 Ports, in order (direction, width, meaning):
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- cs_in  in  1  SPI chip select, active-low, asynchronous.
- sck_in  in  1  SPI clock, asynchronous.
- mosi_in  in  1  SPI data in, LSB first.
- miso_out  out  1  SPI data out, LSB first.
- en_load  in  1  SPI sampling permitted (HSYNC window or display off).
- bg_color_out  out  COLOR_W  background color.
- poly_color_out  out  NUM_POLY*COLOR_W  colors packed; slot k occupies bits [k*COLOR_W +: COLOR_W].
- v{0,1,2}_x_out  out  NUM_POLY*X_W  packed x per vertex.
- v{0,1,2}_y_out  out  NUM_POLY*Y_W  packed y per vertex.
- poly_enable_out  out  NUM_POLY  per-slot enable.
- frame_done  out  1  one-clk pulse per accepted complete frame.
- cmd_err  out  1  one-clk pulse per rejected complete frame.

Function
REQ-005 Synchronisation: sck via a 3-flop chain; cs and mosi via 2-flop chains. rise = synced {prev,cur} == 01; fall = 10.
REQ-006 FSM states: IDLE (synced cs high), CMD (bit count < 8), PAYLOAD (8 <= count < FRAME_W), DONE (count == FRAME_W). Synced cs high forces IDLE, count 0, shift buffer 0 from any state.
REQ-007 A bit is sampled only when rise & en_load & state != DONE. Bits arriving in DONE are ignored until cs goes high.
REQ-008 Buffer bit i = i-th received bit. Cmd = bits[7:0]. Payload, LSB first: color, v0_x, v1_x, v2_x, v0_y, v1_y, v2_y.
REQ-009 Commit: on the clk after entry to DONE, cmd is decoded exactly once per frame.
- 0x80|k: load slot k; set enable[k].
- 0x40|k: zero slot k; clear enable[k].
- 0x01: bg_color = payload color.
- k occupies cmd[2:0].
REQ-010 frame_done pulses in the commit cycle for valid commands; outputs reflect new values the same cycle.
REQ-011 Unknown cmd, or k >= NUM_POLY: no register changes; cmd_err pulses instead of frame_done.
REQ-012 cs high before DONE: frame discarded; no register change; no pulse.
REQ-013 Outputs are driven directly from registers; there is no combinational path from SPI inputs to outputs.

Reset
REQ-014 While rst_n is low: all registers, enables, and bg_color are 0; state IDLE; miso_out 0; frame_done and cmd_err 0.
REQ-015 Reset asserted mid-frame aborts the frame. A reset coinciding with the commit cycle wins; no commit occurs.

Configuration
REQ-016 With macro POLY_SPI_READBACK_EN defined:
- Cmd 0xC0|k with k < NUM_POLY loads a tx shift register with slot k's packed payload (REQ-008 order) on the clk the 8th bit is sampled.
- Bit 0 drives miso_out from the next sck fall; each further fall shifts one bit.
- miso_out is 0 outside a read frame.
- The completed read frame pulses frame_done and alters no register.
REQ-017 Without POLY_SPI_READBACK_EN: 0xC0-range commands take the REQ-011 path; miso_out is tied 0; no tx logic is built.

Structure
REQ-018 Package poly_spi_pkg holds the command opcodes, the width defaults, the FRAME_W function, and the FSM state enum.
REQ-019 One sub-module, poly_spi_sampler, contains the synchronisers and the rise/fall detection.

Verification
REQ-020 Defaults apply to all scenarios below.
- Write slot 2 (cmd 0x82): color 0x2A, v0 (0x10,0x05), v1 (0x7F,0x3F), v2 (0x00,0x01). poly_color_out[17:12] = 0x2A; v1_x_out[20:14] = 0x7F; enable = 0100; one frame_done.
- Cmd 0x42 after the above: slot 2 fields = 0; enable[2] = 0; other slots unchanged.
- 30 bits, then cs high: no register change; no pulse. A following valid 0x01 frame, color 0x15: bg_color_out = 0x15.
- Cmd 0x85 (NUM_POLY=4): cmd_err pulse; outputs unchanged. With en_load = 0 throughout, no bits are counted and no pulse occurs.
- READBACK_EN: after the first scenario, cmd 0xC2 with 45 dummy bits. miso_out stream = 0x2A, 0x10, 0x7F, 0x00, 0x05, 0x3F, 0x01 LSB-first; frame_done pulses once.
